// File: rtl/threshold_bank.sv
// threshold_bank: bank of user-adjustable thresholds for the lighting pipeline.
// Up/down buttons step the one-hot selected channel once per tick. The step is
// slow at first and switches to fast after a steady hold. Values saturate at
// MIN_VALUE/MAX_VALUE, and a clear pulse resets the selected channel.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   up, down    - level buttons (synchronous, debounced upstream)
//   sel         - one-hot channel select
//   clear       - pulse, sets the selected channel to MIN_VALUE
//   thresholds  - flat bus, channel i at [i*VALUE_WIDTH +: VALUE_WIDTH]
//   changed     - one-cycle pulse after any threshold value changed
//   fast        - high while the accelerated step is in effect
module threshold_bank #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned VALUE_WIDTH  = 10,
  parameter int unsigned MIN_VALUE    = 0,
  parameter int unsigned MAX_VALUE    = 359,
  parameter int unsigned TICK_PERIOD  = 3062500,
  parameter int unsigned STEP_SLOW    = 1,
  parameter int unsigned STEP_FAST    = 4,
  parameter int unsigned HOLD_TICKS   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                up,
  input  logic                                down,
  input  logic [NUM_CHANNELS-1:0]             sel,
  input  logic                                clear,
  output logic [NUM_CHANNELS*VALUE_WIDTH-1:0] thresholds,
  output logic                                changed,
  output logic                                fast
);

  localparam int unsigned CNT_W   = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);
  localparam int unsigned ARITH_W = VALUE_WIDTH + 1;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_INC  = 2'd1;
  localparam logic [1:0] DIR_DEC  = 2'd2;

  logic [CNT_W-1:0]        cnt_q;
  logic                    tick;
  logic [1:0]              dir;
  logic [1:0]              dir_q;
  logic [NUM_CHANNELS-1:0] sel_q;
  logic                    sel_valid;
  logic                    hold_clr;
  logic [HOLD_W-1:0]       hold_q;
  logic [HOLD_W-1:0]       hold_eff;
  logic [HOLD_W-1:0]       hold_next;
  logic [ARITH_W-1:0]      step;
  logic [VALUE_WIDTH-1:0]  old_val;
  logic [VALUE_WIDTH-1:0]  new_val;
  logic [ARITH_W-1:0]      sum;
  logic signed [ARITH_W-1:0] diff;
  logic                    any_diff;
  logic [VALUE_WIDTH-1:0]  thr_q    [NUM_CHANNELS];
  logic [VALUE_WIDTH-1:0]  thr_next [NUM_CHANNELS];

  // Free-running tick counter, independent of buttons, sel and clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == CNT_W'(TICK_PERIOD - 1));

  // Button decode: both or neither pressed means no direction
  always_comb begin
    dir = DIR_NONE;
    if (up && !down) begin
      dir = DIR_INC;
    end else if (down && !up) begin
      dir = DIR_DEC;
    end
  end

  assign sel_valid = (sel != '0) && ((sel & (sel - NUM_CHANNELS'(1))) == '0);

  // Any break in a steady hold restarts acceleration, including on the tick itself
  assign hold_clr = (dir == DIR_NONE) || (dir != dir_q) || (sel != sel_q) ||
                    !sel_valid || clear;
  assign hold_eff = hold_clr ? '0 : hold_q;
  assign step     = (hold_eff == HOLD_W'(HOLD_TICKS)) ? ARITH_W'(STEP_FAST)
                                                      : ARITH_W'(STEP_SLOW);

  always_comb begin
    hold_next = hold_eff;
    if (tick && !hold_clr && (hold_q != HOLD_W'(HOLD_TICKS))) begin
      hold_next = hold_q + HOLD_W'(1);
    end
  end

  // Selected channel's current value (only meaningful when sel is one-hot)
  always_comb begin
    old_val = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (sel[i]) begin
        old_val = thr_q[i];
      end
    end
  end

  // One extra bit of headroom so neither direction can wrap before clamping
  assign sum  = {1'b0, old_val} + step;
  assign diff = $signed({1'b0, old_val}) - $signed(step);

  always_comb begin
    new_val = old_val;
    if (dir == DIR_INC) begin
      new_val = (sum > ARITH_W'(MAX_VALUE)) ? VALUE_WIDTH'(MAX_VALUE)
                                            : sum[VALUE_WIDTH-1:0];
    end else if (dir == DIR_DEC) begin
      new_val = (diff < $signed(ARITH_W'(MIN_VALUE))) ? VALUE_WIDTH'(MIN_VALUE)
                                                      : diff[VALUE_WIDTH-1:0];
    end
  end

  // Per-channel next value; clear wins over a coincident tick update
  always_comb begin
    any_diff = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      thr_next[i] = thr_q[i];
      if (sel_valid && sel[i]) begin
        if (clear) begin
          thr_next[i] = VALUE_WIDTH'(MIN_VALUE);
        end else if (tick) begin
          thr_next[i] = new_val;
        end
      end
      if (thr_next[i] != thr_q[i]) begin
        any_diff = 1'b1;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        thr_q[i] <= VALUE_WIDTH'(MIN_VALUE);
      end
      hold_q  <= '0;
      dir_q   <= DIR_NONE;
      sel_q   <= '0;
      changed <= 1'b0;
      fast    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        thr_q[i] <= thr_next[i];
      end
      hold_q  <= hold_next;
      dir_q   <= dir;
      sel_q   <= sel;
      changed <= any_diff;
      fast    <= (hold_next == HOLD_W'(HOLD_TICKS));
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
    assign thresholds[g*VALUE_WIDTH +: VALUE_WIDTH] = thr_q[g];
  end

endmodule

// File: tb/tb_threshold_bank.sv
// tb_threshold_bank: directed, table-driven bench for threshold_bank with a
// short tick period. A second instance with a small range and a large slow
// step covers the decrement clamp.
module tb_threshold_bank;

  localparam int unsigned NCH = 3;
  localparam int unsigned VW  = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           up, down, clear;
  logic [NCH-1:0] sel;
  logic [NCH*VW-1:0] thr;
  logic           changed, fast;

  logic           up2, down2, clear2;
  logic [NCH-1:0] sel2;
  logic [NCH*VW-1:0] thr2;
  logic           changed2, fast2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       up;
    logic       down;
    logic [2:0] sel;
    logic       clr;
    int         e0;
    int         e1;
    int         e2;
    logic       echg;
    logic       efast;
  } vec_t;

  vec_t vecs[$];

  threshold_bank #(
    .NUM_CHANNELS(NCH), .VALUE_WIDTH(VW), .MIN_VALUE(0), .MAX_VALUE(359),
    .TICK_PERIOD(4), .STEP_SLOW(1), .STEP_FAST(4), .HOLD_TICKS(8)
  ) u_dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .sel(sel), .clear(clear),
    .thresholds(thr), .changed(changed), .fast(fast)
  );

  threshold_bank #(
    .NUM_CHANNELS(NCH), .VALUE_WIDTH(VW), .MIN_VALUE(0), .MAX_VALUE(3),
    .TICK_PERIOD(4), .STEP_SLOW(4), .STEP_FAST(4), .HOLD_TICKS(8)
  ) u_dut2 (
    .clk(clk), .rst(rst), .up(up2), .down(down2), .sel(sel2), .clear(clear2),
    .thresholds(thr2), .changed(changed2), .fast(fast2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bank(input string tag, input int e0, input int e1, input int e2,
                            input logic echg, input logic efast);
    check({tag, " ch0"}, 32'(thr[0*VW +: VW]), 32'(e0));
    check({tag, " ch1"}, 32'(thr[1*VW +: VW]), 32'(e1));
    check({tag, " ch2"}, 32'(thr[2*VW +: VW]), 32'(e2));
    check({tag, " changed"}, 32'(changed), 32'(echg));
    check({tag, " fast"}, 32'(fast), 32'(efast));
  endtask

  // n rising edges, then settle on the following falling edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic u, input logic d, input logic [2:0] s, input logic c,
                     input int e0, input int e1, input int e2,
                     input logic echg, input logic efast);
    vec_t v;
    v.up = u; v.down = d; v.sel = s; v.clr = c;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.echg = echg; v.efast = efast;
    vecs.push_back(v);
  endtask

  // Each row spans exactly one tick period; starts on the falling edge after an update edge
  task automatic run_rows(input int first, input int last);
    for (int r = first; r < last; r++) begin
      up = vecs[r].up; down = vecs[r].down; sel = vecs[r].sel;
      cyc(1);
      check($sformatf("row%0d idle changed", r), 32'(changed), 32'd0);
      cyc(2);
      if (vecs[r].clr) clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      check_bank($sformatf("row%0d", r), vecs[r].e0, vecs[r].e1, vecs[r].e2,
                 vecs[r].echg, vecs[r].efast);
    end
  endtask

  initial begin
    int n1;
    int v;
    int h;
    int stp;
    bit done;

    // Segment 1: acceleration on ch0, both-buttons, release, clear coincident with tick
    for (int k = 1; k <= 12; k++) begin
      v = (k <= 8) ? k : 8 + 4 * (k - 8);
      add(1, 0, 3'b001, 0, v, 0, 0, 1, (k >= 8));
    end
    for (int k = 0; k < 5; k++) add(1, 1, 3'b001, 0, 24, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(1, 0, 3'b001, 0, 24 + k, 0, 0, 1, (k == 8));
    for (int k = 1; k <= 4; k++) add(1, 0, 3'b001, 0, 32 + 4 * k, 0, 0, 1, 1);
    add(0, 0, 3'b001, 0, 48, 0, 0, 0, 0);
    add(1, 0, 3'b001, 0, 49, 0, 0, 1, 0);
    add(1, 0, 3'b001, 0, 50, 0, 0, 1, 0);
    add(1, 0, 3'b001, 1, 0, 0, 0, 1, 0);
    add(1, 0, 3'b001, 0, 1, 0, 0, 1, 0);
    n1 = vecs.size();
    // Segment 2: re-accelerate ch0, sel switch mid-hold, invalid selects, then fast again
    for (int k = 1; k <= 8; k++) add(1, 0, 3'b001, 0, 1 + k, 0, 0, 1, (k == 8));
    add(1, 0, 3'b010, 0, 9, 1, 0, 1, 0);
    add(1, 0, 3'b000, 0, 9, 1, 0, 0, 0);
    add(1, 0, 3'b011, 0, 9, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(1, 0, 3'b001, 0, 9 + k, 1, 0, 1, (k == 8));

    rst = 1'b1; up = 0; down = 0; sel = '0; clear = 0;
    up2 = 0; down2 = 0; sel2 = '0; clear2 = 0;
    #3;
    check_bank("reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_rows(0, n1);

    // Saturate ch1 against a small reference model of the stepping rule
    v = 0; h = 0; done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      up = 1; down = 0; sel = 3'b010;
      cyc(4);
      stp = (h == 8) ? 4 : 1;
      v = (v + stp > 359) ? 359 : v + stp;
      h = (h < 8) ? h + 1 : 8;
      check($sformatf("sat t%0d ch1", t), 32'(thr[1*VW +: VW]), 32'(v));
      check($sformatf("sat t%0d changed", t), 32'(changed), 32'd1);
      if (v == 359) done = 1;
    end
    check("sat reached", 32'(done), 32'd1);
    cyc(4);
    check_bank("sat hold", 1, 359, 0, 0, 1);

    // Standalone clear of ch1, then realign to the tick grid
    up = 0; sel = 3'b010; clear = 1;
    cyc(1);
    clear = 0;
    check_bank("clear ch1", 1, 0, 0, 1, 0);
    cyc(3);
    check_bank("after clear", 1, 0, 0, 0, 0);

    run_rows(n1, vecs.size());

    // Asynchronous reset mid-hold, right after a change pulse and with fast high
    #2 rst = 1'b1;
    #1 check_bank("async reset", 0, 0, 0, 0, 0);
    check("async reset dut2 ch2", 32'(thr2[2*VW +: VW]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    up2 = 1; sel2 = 3'b100;
    cyc(3);
    check_bank("pre first tick", 0, 0, 0, 0, 0);
    cyc(1);
    check_bank("first tick", 1, 0, 0, 1, 0);
    check("dut2 up clamp ch2", 32'(thr2[2*VW +: VW]), 32'd3);
    check("dut2 up changed", 32'(changed2), 32'd1);

    // Decrement clamp on the second instance: 3 - 4 saturates at 0
    up2 = 0; down2 = 1;
    cyc(4);
    check("dut2 dec clamp ch2", 32'(thr2[2*VW +: VW]), 32'd0);
    check("dut2 dec changed", 32'(changed2), 32'd1);
    cyc(4);
    check("dut2 dec hold ch2", 32'(thr2[2*VW +: VW]), 32'd0);
    check("dut2 dec no change", 32'(changed2), 32'd0);
    check("dut2 other channels", 32'(thr2[0 +: 2*VW]), 32'd0);
    check("dut2 fast", 32'(fast2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
